// File: rtl/bp_be_fe_queue_ctrl_if.sv
// rtl/bp_be_fe_queue_ctrl_if.sv - FE/BE queue controller handshake bundle
interface bp_be_fe_queue_ctrl_if #(
    parameter int fe_queue_width_p = 128,
    parameter int fe_cmd_width_p   = 128
);
    logic [fe_queue_width_p-1:0] fe_queue_i;
    logic                        fe_queue_v_i;
    logic                        fe_queue_ready_o;
    logic [fe_queue_width_p-1:0] issue_pkt_o;
    logic                        issue_v_o;
    logic                        issue_yumi_i;
    logic                        commit_v_i;
    logic                        roll_v_i;
    logic [fe_cmd_width_p-1:0]   cmd_i;
    logic                        cmd_nonattaboy_i;
    logic                        cmd_v_i;
    logic                        cmd_ready_o;
    logic [fe_cmd_width_p-1:0]   fe_cmd_o;
    logic                        fe_cmd_v_o;
    logic                        fe_cmd_yumi_i;
    logic                        drain_o;

    modport slave (
        input  fe_queue_i, fe_queue_v_i, issue_yumi_i, commit_v_i, roll_v_i,
               cmd_i, cmd_nonattaboy_i, cmd_v_i, fe_cmd_yumi_i,
        output fe_queue_ready_o, issue_pkt_o, issue_v_o, cmd_ready_o,
               fe_cmd_o, fe_cmd_v_o, drain_o
    );

    modport master (
        output fe_queue_i, fe_queue_v_i, issue_yumi_i, commit_v_i, roll_v_i,
               cmd_i, cmd_nonattaboy_i, cmd_v_i, fe_cmd_yumi_i,
        input  fe_queue_ready_o, issue_pkt_o, issue_v_o, cmd_ready_o,
               fe_cmd_o, fe_cmd_v_o, drain_o
    );
endinterface

// File: rtl/bp_be_fe_queue_ctrl.sv
// rtl/bp_be_fe_queue_ctrl.sv - speculative fetch FIFO plus command FIFO with redirect drain
module bp_be_fe_queue_ctrl #(
    parameter int fe_queue_width_p = 128,
    parameter int fe_cmd_width_p   = 128,
    parameter int fe_queue_els_p   = 8,
    parameter int fe_cmd_els_p     = 4
) (
    input logic                   clk_i,
    input logic                   reset_n_i,
    bp_be_fe_queue_ctrl_if.slave  bus
);
    localparam int QPW = $clog2(fe_queue_els_p) + 1;
    localparam int CPW = $clog2(fe_cmd_els_p) + 1;

    typedef enum logic [0:0] {e_run, e_drain} state_e;

    state_e                      r_state, w_state_n;
    logic [QPW-1:0]              r_wr, r_rd, r_cmt;
    logic [QPW-1:0]              w_wr_n, w_rd_n, w_cmt_n, w_occ;
    logic [CPW-1:0]              r_cwr, r_crd, r_pend, w_pend_n, w_cocc;
    logic [fe_queue_width_p-1:0] r_qmem [fe_queue_els_p];
    logic [fe_cmd_width_p:0]     r_cmem [fe_cmd_els_p];
    logic [fe_cmd_width_p:0]     w_head;
    logic                        w_drain, w_full, w_cfull, w_cempty;
    logic                        w_q_enq, w_cmd_enq, w_cmd_deq, w_flush;
    logic                        w_pend_inc, w_pend_dec;

    assign w_drain  = (r_state == e_drain);
    assign w_occ    = r_wr - r_cmt;
    assign w_full   = (w_occ == QPW'(fe_queue_els_p));
    assign w_cocc   = r_cwr - r_crd;
    assign w_cfull  = (w_cocc == CPW'(fe_cmd_els_p));
    assign w_cempty = (r_cwr == r_crd);
    assign w_head   = r_cmem[r_crd[CPW-2:0]];

    assign w_cmd_enq  = bus.cmd_v_i & ~w_cfull;
    assign w_cmd_deq  = bus.fe_cmd_yumi_i & ~w_cempty;
    assign w_flush    = w_cmd_enq & bus.cmd_nonattaboy_i;
    assign w_pend_inc = w_flush;
    assign w_pend_dec = w_cmd_deq & w_head[fe_cmd_width_p];
    // Packets arriving while draining or in the flush cycle are accepted and discarded.
    assign w_q_enq    = bus.fe_queue_v_i & ~w_full & ~w_drain & ~w_flush;

    assign bus.fe_queue_ready_o = w_drain | ~w_full;
    assign bus.issue_v_o        = (r_rd != r_wr) & ~w_drain;
    assign bus.issue_pkt_o      = r_qmem[r_rd[QPW-2:0]];
    assign bus.cmd_ready_o      = ~w_cfull;
    assign bus.fe_cmd_v_o       = ~w_cempty;
    assign bus.fe_cmd_o         = w_head[fe_cmd_width_p-1:0];
    assign bus.drain_o          = w_drain;

    always_comb begin
        w_wr_n  = r_wr;
        w_rd_n  = r_rd;
        w_cmt_n = r_cmt;
        if (w_flush) begin
            w_wr_n = r_cmt;
            w_rd_n = r_cmt;
        end else begin
            if (w_q_enq)
                w_wr_n = r_wr + QPW'(1);
            if (bus.commit_v_i)
                w_cmt_n = r_cmt + QPW'(1);
            // Replay restarts from the post-commit pointer and beats a same-cycle issue.
            if (bus.roll_v_i)
                w_rd_n = w_cmt_n;
            else if (bus.issue_yumi_i)
                w_rd_n = r_rd + QPW'(1);
        end
    end

    always_comb begin
        w_pend_n = r_pend;
        if (w_pend_inc && !w_pend_dec)
            w_pend_n = r_pend + CPW'(1);
        else if (!w_pend_inc && w_pend_dec)
            w_pend_n = r_pend - CPW'(1);
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            e_run:   if (w_flush) w_state_n = e_drain;
            e_drain: if (!w_flush && w_pend_n == '0) w_state_n = e_run;
            default: w_state_n = e_run;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_run;
            r_wr    <= '0;
            r_rd    <= '0;
            r_cmt   <= '0;
            r_cwr   <= '0;
            r_crd   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_n;
            r_wr    <= w_wr_n;
            r_rd    <= w_rd_n;
            r_cmt   <= w_cmt_n;
            r_pend  <= w_pend_n;
            if (w_cmd_enq)
                r_cwr <= r_cwr + CPW'(1);
            if (w_cmd_deq)
                r_crd <= r_crd + CPW'(1);
        end
    end

    // Storage arrays carry no reset; pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (w_q_enq)
            r_qmem[r_wr[QPW-2:0]] <= bus.fe_queue_i;
        if (w_cmd_enq)
            r_cmem[r_cwr[CPW-2:0]] <= {bus.cmd_nonattaboy_i, bus.cmd_i};
    end

    a_commit_has_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.commit_v_i |-> (r_rd != r_cmt));
    a_yumi_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.issue_yumi_i |-> bus.issue_v_o);
endmodule

// File: tb/tb_bp_be_fe_queue_ctrl.sv
// tb/tb_bp_be_fe_queue_ctrl.sv - randomized and directed bench against a queue-based model
module tb_bp_be_fe_queue_ctrl;
    localparam int QW = 128;
    localparam int CW = 128;
    localparam int QE = 8;
    localparam int CE = 4;
    localparam int W  = CW + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_be_fe_queue_ctrl_if #(.fe_queue_width_p(QW), .fe_cmd_width_p(CW)) bus();

    bp_be_fe_queue_ctrl #(
        .fe_queue_width_p(QW), .fe_cmd_width_p(CW),
        .fe_queue_els_p(QE), .fe_cmd_els_p(CE)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .bus(bus)
    );

    // Model: uncommitted packets in order, how many of them are issued, and the command list.
    logic [QW-1:0] m_fq[$];
    int            m_iss;
    logic [CW:0]   m_cq[$];
    bit            m_drain;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic bit m_iv();
        return !m_drain && (m_iss < m_fq.size());
    endfunction

    task automatic model_reset();
        m_fq.delete();
        m_cq.delete();
        m_iss   = 0;
        m_drain = 0;
    endtask

    task automatic check_outputs();
        check_val("fe_queue_ready", W'(bus.fe_queue_ready_o), W'(m_drain || m_fq.size() < QE));
        check_val("issue_v", W'(bus.issue_v_o), W'(m_iv()));
        if (m_iv())
            check_val("issue_pkt", W'(bus.issue_pkt_o), W'(m_fq[m_iss]));
        check_val("cmd_ready", W'(bus.cmd_ready_o), W'(m_cq.size() < CE));
        check_val("fe_cmd_v", W'(bus.fe_cmd_v_o), W'(m_cq.size() > 0));
        if (m_cq.size() > 0)
            check_val("fe_cmd", W'(bus.fe_cmd_o), W'(m_cq[0][CW-1:0]));
        check_val("drain", W'(bus.drain_o), W'(m_drain));
    endtask

    task automatic step(input logic fv, input logic [QW-1:0] fd, input logic iy, input logic cm,
                        input logic rl, input logic cv, input logic cna, input logic [CW-1:0] cd,
                        input logic cy);
        bit c_rdy, cenq, flush, q_rdy, qenq;
        int na;
        check_outputs();
        bus.fe_queue_v_i     = fv;
        bus.fe_queue_i       = fd;
        bus.issue_yumi_i     = iy;
        bus.commit_v_i       = cm;
        bus.roll_v_i         = rl;
        bus.cmd_v_i          = cv;
        bus.cmd_nonattaboy_i = cna;
        bus.cmd_i            = cd;
        bus.fe_cmd_yumi_i    = cy;
        @(posedge clk);
        c_rdy = m_cq.size() < CE;
        cenq  = cv && c_rdy;
        flush = cenq && cna;
        q_rdy = m_drain || m_fq.size() < QE;
        qenq  = fv && q_rdy && !m_drain && !flush;
        if (cy && m_cq.size() > 0)
            void'(m_cq.pop_front());
        if (cenq)
            m_cq.push_back({cna, cd});
        if (flush) begin
            m_fq.delete();
            m_iss = 0;
        end else begin
            if (cm) begin
                void'(m_fq.pop_front());
                m_iss--;
            end
            if (rl)
                m_iss = 0;
            else if (iy)
                m_iss++;
            if (qenq)
                m_fq.push_back(fd);
        end
        na = 0;
        foreach (m_cq[i])
            if (m_cq[i][CW])
                na++;
        if (flush)
            m_drain = 1;
        else if (na == 0)
            m_drain = 0;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.fe_queue_v_i = 0; bus.fe_queue_i = '0; bus.issue_yumi_i = 0; bus.commit_v_i = 0;
        bus.roll_v_i = 0; bus.cmd_v_i = 0; bus.cmd_nonattaboy_i = 0; bus.cmd_i = '0;
        bus.fe_cmd_yumi_i = 0;
    endtask

    task automatic rand_step();
        logic fv, iy, cm, rl, cv, cna, cy;
        logic [QW-1:0] fd;
        logic [CW-1:0] cd;
        fv  = 1'($urandom_range(0, 1));
        fd  = {$urandom, $urandom, $urandom, $urandom};
        iy  = m_iv() && ($urandom_range(0, 2) != 0);
        cm  = (m_iss > 0) && ($urandom_range(0, 3) == 0);
        rl  = ($urandom_range(0, 15) == 0);
        cv  = ($urandom_range(0, 3) == 0);
        cna = ($urandom_range(0, 3) == 0);
        cd  = {$urandom, $urandom, $urandom, $urandom};
        cy  = (m_cq.size() > 0) && ($urandom_range(0, 1) == 1);
        step(fv, fd, iy, cm, rl, cv, cna, cd, cy);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("rst_ready", W'(bus.fe_queue_ready_o), W'(1));
        check_val("rst_issue_v", W'(bus.issue_v_o), W'(0));
        check_val("rst_cmd_ready", W'(bus.cmd_ready_o), W'(1));
        check_val("rst_fe_cmd_v", W'(bus.fe_cmd_v_o), W'(0));
        check_val("rst_drain", W'(bus.drain_o), W'(0));

        // Fill to capacity, then issue everything in order.
        for (int i = 0; i < QE; i++)
            step(1, QW'(i), 0, 0, 0, 0, 0, '0, 0);
        check_val("fill_ready_low", W'(bus.fe_queue_ready_o), W'(0));
        for (int i = 0; i < QE; i++) begin
            check_val("fill_order", W'(bus.issue_pkt_o), W'(i));
            step(0, '0, 1, 0, 0, 0, 0, '0, 0);
        end
        check_val("empty_issue_v", W'(bus.issue_v_o), W'(0));
        for (int i = 0; i < QE; i++)
            step(0, '0, 0, 1, 0, 0, 0, '0, 0);

        // Rollback replays from the oldest uncommitted packet.
        for (int i = 0; i < 4; i++)
            step(1, QW'(i), 0, 0, 0, 0, 0, '0, 0);
        for (int i = 0; i < 3; i++)
            step(0, '0, 1, 0, 0, 0, 0, '0, 0);
        step(0, '0, 0, 1, 0, 0, 0, '0, 0);
        step(0, '0, 0, 0, 1, 0, 0, '0, 0);
        check_val("roll_pkt", W'(bus.issue_pkt_o), W'(1));
        check_val("roll_ready", W'(bus.fe_queue_ready_o), W'(1));

        // Redirect with three packets queued; FE delays the command.
        step(0, '0, 0, 0, 0, 1, 1, CW'(32'hC0DE), 0);
        for (int i = 0; i < 5; i++) begin
            check_val("redir_drain", W'(bus.drain_o), W'(1));
            check_val("redir_issue_v", W'(bus.issue_v_o), W'(0));
            step(1, QW'(8'h20 + i), 0, 0, 0, 0, 0, '0, 0);
        end
        step(0, '0, 0, 0, 0, 0, 0, '0, 1);
        check_val("redir_done", W'(bus.drain_o), W'(0));
        step(1, QW'(8'hA), 0, 0, 0, 0, 0, '0, 0);
        check_val("redir_next_v", W'(bus.issue_v_o), W'(1));
        check_val("redir_next_pkt", W'(bus.issue_pkt_o), W'(8'hA));
        step(0, '0, 1, 0, 0, 0, 0, '0, 0);
        step(0, '0, 0, 1, 0, 0, 0, '0, 0);

        // Attaboys while streaming: no flush, command FIFO fills, order preserved.
        for (int i = 0; i < CE; i++) begin
            step(1, QW'(8'h10 + i), 0, 0, 0, 1, 0, CW'(16'h100 + i), 0);
            check_val("atta_drain", W'(bus.drain_o), W'(0));
        end
        check_val("atta_cmd_full", W'(bus.cmd_ready_o), W'(0));
        check_val("atta_no_flush", W'(bus.issue_pkt_o), W'(8'h10));
        for (int i = 0; i < CE; i++) begin
            check_val("atta_order", W'(bus.fe_cmd_o), W'(16'h100 + i));
            step(0, '0, 0, 0, 0, 0, 0, '0, 1);
        end

        // Back-to-back redirects; a packet in the final yumi cycle is dropped.
        step(0, '0, 0, 0, 0, 1, 1, CW'(8'hB1), 0);
        step(0, '0, 0, 0, 0, 1, 1, CW'(8'hB2), 0);
        step(0, '0, 0, 0, 0, 0, 0, '0, 1);
        check_val("b2b_still_drain", W'(bus.drain_o), W'(1));
        step(1, QW'(8'h55), 0, 0, 0, 0, 0, '0, 1);
        check_val("b2b_drain_off", W'(bus.drain_o), W'(0));
        check_val("b2b_dropped", W'(bus.issue_v_o), W'(0));

        for (int i = 0; i < 3000; i++)
            rand_step();

        // Bring both FIFOs to a partly filled state, then reset between edges.
        for (int i = 0; i < 8; i++)
            step(0, '0, 0, 0, 0, 0, 0, '0, m_cq.size() > 0);
        for (int i = 0; i < 4; i++)
            step(1, QW'(8'h60 + i), 0, 0, 0, i < 2, 0, CW'(8'h70 + i), 0);
        check_val("pre_rst_issue_v", W'(bus.issue_v_o), W'(m_iv()));
        check_val("pre_rst_fe_cmd_v", W'(bus.fe_cmd_v_o), W'(m_cq.size() > 0));
        idle_inputs();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_issue_v", W'(bus.issue_v_o), W'(0));
        check_val("arst_fe_cmd_v", W'(bus.fe_cmd_v_o), W'(0));
        check_val("arst_drain", W'(bus.drain_o), W'(0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_val("post_rst_ready", W'(bus.fe_queue_ready_o), W'(1));
        check_val("post_rst_cmd_ready", W'(bus.cmd_ready_o), W'(1));

        for (int i = 0; i < 500; i++)
            rand_step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/bp_be_fe_queue_ctrl.md
Name: bp_be_fe_queue_ctrl

Overview:
- Back-end-side endpoint of the FE/BE interface: accepts fe_queue packets from the front end and returns fe_cmd packets to it.
- Buffers fetched packets in a speculative FIFO with commit/rollback pointers and serialises BE-generated commands into a small command FIFO.
- After any non-attaboy command is enqueued, it drops stale fe_queue traffic until the FE has accepted every such command.
- Sits between bp_fe_top and the BE issue/commit logic.

Parameters:
- fe_queue_width_p, 128, width of one fe_queue packet (opaque).
- fe_cmd_width_p, 128, width of one fe_cmd packet (opaque).
- fe_queue_els_p, 8, fetch FIFO depth; power of 2, ≥2.
- fe_cmd_els_p, 4, command FIFO depth; power of 2, ≥2.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- fe_queue_i  in  fe_queue_width_p  packet from FE.
- fe_queue_v_i  in  1  packet valid; may depend combinationally on fe_queue_ready_o.
- fe_queue_ready_o  out  1  space available; must not depend on fe_queue_v_i.
- issue_pkt_o  out  fe_queue_width_p  oldest unissued packet.
- issue_v_o  out  1  issue_pkt_o valid.
- issue_yumi_i  in  1  BE consumes issue_pkt_o; only legal when issue_v_o=1.
- commit_v_i  in  1  oldest issued packet retires.
- roll_v_i  in  1  replay all issued, uncommitted packets.
- cmd_i  in  fe_cmd_width_p  command from BE.
- cmd_nonattaboy_i  in  1  cmd_i is a redirect/fence/fill/reset (not attaboy).
- cmd_v_i  in  1  command valid.
- cmd_ready_o  out  1  command FIFO not full; independent of cmd_v_i.
- fe_cmd_o  out  fe_cmd_width_p  head command to FE.
- fe_cmd_v_o  out  1  head valid.
- fe_cmd_yumi_i  in  1  FE consumes head; may depend on fe_cmd_v_o.
- drain_o  out  1  high while dropping stale fe_queue traffic.

Behaviour:
- Reset (async assert, sync-safe deassert): all pointers 0, pending count 0, state e_run.
  - Reset output values: fe_queue_ready_o=1, issue_v_o=0, cmd_ready_o=1, fe_cmd_v_o=0, drain_o=0.
- Fetch FIFO pointers:
  - Three pointers, wr/rd/cmt, each log2(fe_queue_els_p)+1 bits wide, wrapping modulo 2*els.
  - occupancy = wr-cmt; full = occupancy==els; fe_queue_ready_o = ~full.
  - issue_v_o = (rd!=wr) & ~drain_o. issue_pkt_o = mem[rd], combinational read, zero latency.
- Fetch FIFO updates:
  - Enqueue when fe_queue_v_i & fe_queue_ready_o & state==e_run: write mem[wr], wr++.
  - A packet written in cycle N is visible on issue_pkt_o in N+1.
  - issue_yumi_i: rd++.
  - commit_v_i: cmt++. Committing with rd==cmt is illegal; assertion required.
  - roll_v_i: rd <- cmt (post-commit value when commit_v_i is high the same cycle).
  - Roll in the same cycle as issue_yumi_i: roll wins.
- Command FIFO:
  - Standard circular buffer. Enqueue on cmd_v_i & cmd_ready_o; storage includes the nonattaboy bit.
  - fe_cmd_v_o = ~empty; fe_cmd_o = head; dequeue on fe_cmd_yumi_i.
  - Enqueue and dequeue in the same cycle are allowed when full: ready stays low, so no enqueue.
- Pending counter (log2(fe_cmd_els_p)+1 bits):
  - Increments when a nonattaboy command is enqueued.
  - Decrements when fe_cmd_yumi_i pops a nonattaboy head.
  - Both in the same cycle: count unchanged.
- Flush: on nonattaboy enqueue, wr, rd and cmt are all set to cmt+0, which empties the FIFO.
  - Flush overrides commit, roll and issue in that cycle.
  - Any fe_queue packet arriving in the flush cycle is dropped.
- State machine:
  - e_run -> e_drain on nonattaboy enqueue.
  - e_drain -> e_run when the pending count becomes 0 with no nonattaboy enqueue that cycle; transition takes effect at the next edge.
  - drain_o = (state==e_drain).
  - In e_drain: fe_queue_ready_o=1 and every arriving packet is accepted and discarded, including one arriving in the same cycle as the final yumi.
  - Attaboy commands never change state or flush.
- Reset mid-operation: all contents discarded, back to the reset values immediately.

Test Plan:
- Fill/empty: after reset push 8 packets (tags 0..7) with no yumi -> ready drops after the 8th. Pop all -> tags issued in order 0..7, then issue_v_o=0.
- Rollback: push 4, yumi 3, commit 1, roll -> issue_pkt_o shows tag 1 again; occupancy stays 3 and ready stays 1.
- Redirect drain: with 3 packets queued, enqueue a nonattaboy cmd while FE holds fe_cmd_yumi_i low for 5 cycles; push 5 packets meanwhile.
  - Required: drain_o=1, issue_v_o=0, all 5 packets dropped.
  - After yumi: drain_o=0 the next cycle, and the next packet (tag 0xA) issues.
- Attaboy only: enqueue 4 attaboy cmds while streaming packets -> no flush, drain_o stays 0, cmd_ready_o=0 after the 4th, commands emerge in order.
- Back-to-back redirects: two nonattaboy cmds, FE yumis the first -> still draining until the second is yumi'd. A packet arriving in that yumi cycle is dropped.
- Async reset mid-traffic: assert reset_n_i=0 between edges with both FIFOs half full -> all valids drop immediately. After release: fe_queue_ready_o=1 and cmd_ready_o=1.
